// File: rtl/lsu_pkg.sv
// Purpose: shared definitions for the load/store read-modify-write controller.
//   - one-hot access type encodings carried on LSTypeM
//   - FSM state type
//   - helpers to normalise an access type, classify sub-word accesses and
//     detect misaligned addresses
package lsu_pkg;

  localparam logic [4:0] LS_B  = 5'b10000;
  localparam logic [4:0] LS_H  = 5'b01000;
  localparam logic [4:0] LS_W  = 5'b00100;
  localparam logic [4:0] LS_BU = 5'b00010;
  localparam logic [4:0] LS_HU = 5'b00001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2
  } rmw_state_t;

  // Anything that is not a legal one-hot code, and an unsigned type paired
  // with a store, collapses to a full-word access in the same direction.
  function automatic logic [4:0] norm_type(input logic [4:0] t, input logic we);
    logic [4:0] r;
    case (t)
      LS_B, LS_H, LS_W: r = t;
      LS_BU, LS_HU:     r = we ? LS_W : t;
      default:          r = LS_W;
    endcase
    return r;
  endfunction

  function automatic logic is_subword(input logic [4:0] t);
    return (t == LS_B) || (t == LS_H) || (t == LS_BU) || (t == LS_HU);
  endfunction

  // Expects an already normalised type.
  function automatic logic is_misaligned(input logic [4:0] t, input logic [1:0] off);
    return (((t == LS_H) || (t == LS_HU)) && off[0]) ||
           ((t == LS_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_rmw_ctrl_if.sv
// Purpose: word-wide, single-port data memory bus without byte enables.
// Signals:
//   MemAddr  word address (byte address bits [AW-1:2])
//   MemRE    read strobe; MemRData is valid MEM_LAT cycles later
//   MemWE    write strobe; MemWData is written in the same cycle
//   MemWData full write word
//   MemRData read data from memory
// Handshake: there is no ready/valid back-pressure; a strobe high in a cycle is
// a committed access that cycle, and MemRE/MemWE are never high together.
// Modports: master = load/store controller, slave = memory.
interface lsu_rmw_ctrl_if #(
  parameter int AW = 32
) ();
  logic [AW-3:0] MemAddr;
  logic          MemRE;
  logic          MemWE;
  logic [31:0]   MemWData;
  logic [31:0]   MemRData;

  modport master (output MemAddr, output MemRE, output MemWE, output MemWData,
                  input  MemRData);
  modport slave  (input  MemAddr, input  MemRE, input  MemWE, input  MemWData,
                  output MemRData);
endinterface

// File: rtl/lsu_rmw_ctrl_lane_unit.sv
// Purpose: combinational lane handling for sub-word accesses.
// Ports:
//   i_type   normalised one-hot access type
//   i_off    byte address bits [1:0]
//   i_rdata  word read from memory
//   i_wdata  store data, lane in the low bits
//   o_load   selected lane, sign- (b/h) or zero- (bu/hu) extended; whole word for w
//   o_merge  i_rdata with the selected b/h lane replaced by store data;
//            i_wdata for full-word types
module lane_unit
  import lsu_pkg::*;
(
  input  logic [4:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    // Half lanes only use bit 1; bit 0 is ignored for halfwords.
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_load = i_rdata;
    case (i_type)
      LS_B:    o_load = {{24{w_byte[7]}}, w_byte};
      LS_H:    o_load = {{16{w_half[15]}}, w_half};
      LS_BU:   o_load = {24'd0, w_byte};
      LS_HU:   o_load = {16'd0, w_half};
      default: o_load = i_rdata;
    endcase

    o_merge = i_rdata;
    case (i_type)
      LS_B: o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      LS_H: begin
        if (i_off[1]) o_merge[31:16] = i_wdata[15:0];
        else          o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Purpose: sequences M-stage loads and stores onto a single-port word memory
// with no byte enables. Full-word stores complete in the accept cycle; loads
// wait MEM_LAT cycles for read data; byte/half stores read the word, merge the
// lane and write it back. StallM freezes the pipeline while an access is open.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned h/w accesses
// (Misalign pulse, no memory access); otherwise Misalign is tied 0 and the
// low address bits beyond the lane are ignored.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   ReqM          request; held with operands while StallM=1
//   MemWriteM     1 = store, 0 = load
//   LSTypeM       one-hot b/h/w/bu/hu
//   AddrM         byte address
//   WDataM        store data (lane in low bits)
//   StallM        freeze pipeline
//   LoadValid     1-cycle pulse qualifying LoadData
//   LoadData      extended load result
//   Misalign      1-cycle pulse on a trapped misaligned request
//   o_dbg_state   current FSM state
//   mem           memory bus (master side)
module lsu_rmw_ctrl
  import lsu_pkg::*;
#(
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ReqM,
  input  logic                MemWriteM,
  input  logic [4:0]          LSTypeM,
  input  logic [AW-1:0]       AddrM,
  input  logic [31:0]         WDataM,
  output logic                StallM,
  output logic                LoadValid,
  output logic [31:0]         LoadData,
  output logic                Misalign,
  output rmw_state_t          o_dbg_state,
  lsu_rmw_ctrl_if.master      mem
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  rmw_state_t    r_state;
  logic [1:0]    r_cnt;
  logic          r_we;
  logic [4:0]    r_type;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;

  logic [4:0]    w_type;
  logic          w_accept;
  logic          w_mis;
  logic          w_go;
  logic          w_word_store;
  logic          w_term;
  logic [31:0]   w_load;
  logic [31:0]   w_merge;

  assign w_type       = norm_type(LSTypeM, MemWriteM);
  assign w_accept     = (r_state == IDLE) && ReqM && !reset;
`ifdef MISALIGN_TRAP_EN
  assign w_mis        = is_misaligned(w_type, AddrM[1:0]);
`else
  assign w_mis        = 1'b0;
`endif
  assign w_go         = w_accept && !w_mis;
  assign w_word_store = MemWriteM && !is_subword(w_type);
  assign w_term       = (r_state == RD_WAIT) && (r_cnt == 2'd0);
  assign o_dbg_state  = r_state;

  lane_unit u_lane (
    .i_type  (r_type),
    .i_off   (r_addr[1:0]),
    .i_rdata (mem.MemRData),
    .i_wdata (r_data),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_we    <= 1'b0;
      r_type  <= LS_W;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_we   <= MemWriteM;
            r_type <= w_type;
            r_addr <= AddrM;
            r_data <= WDataM;
            // Full-word stores finish in the accept cycle; everything else reads first.
            if (!w_word_store) begin
              r_state <= RD_WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == 2'd0) begin
            if (r_we) begin
              r_state <= WRITE;
              r_data  <= w_merge;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so an interrupted access
  // never leaks a strobe or a load pulse.
  always_comb begin
    StallM       = 1'b0;
    LoadValid    = 1'b0;
    LoadData     = '0;
    Misalign     = 1'b0;
    mem.MemAddr  = '0;
    mem.MemRE    = 1'b0;
    mem.MemWE    = 1'b0;
    mem.MemWData = '0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_mis) begin
              Misalign = 1'b1;
            end else begin
              mem.MemAddr = AddrM[AW-1:2];
              if (w_word_store) begin
                mem.MemWE    = 1'b1;
                mem.MemWData = WDataM;
              end else begin
                mem.MemRE = 1'b1;
                StallM    = 1'b1;
              end
            end
          end
        end
        RD_WAIT: begin
          mem.MemAddr = r_addr[AW-1:2];
          if (w_term && !r_we) begin
            LoadValid = 1'b1;
            LoadData  = w_load;
          end else begin
            StallM = 1'b1;
          end
        end
        WRITE: begin
          mem.MemAddr  = r_addr[AW-1:2];
          mem.MemWE    = 1'b1;
          mem.MemWData = r_data;
        end
        default: ;
      endcase
    end
  end

endmodule
